vc_rr_arbiter: RTL and testbench
================================

# vc_rr_arbiter

Round-robin scheduler that drains four input virtual-channel FIFOs (VC0..VC3) into a single shared output FIFO (FIFO 4), one VC burst at a time. It consumes the per-FIFO status flags and the per-VC `continuar` enables produced by flow control, and generates the FIFO pop/push strobes plus the datapath mux select. It sits between the flow-control block and the VC-to-output mux in the switch datapath.

## Interface
- `NUM_VC`, 4, number of input VCs; only 4 is supported.
- `BURST_LEN`, 4, maximum pops per grant; legal range 1..15.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `empty`  in  4  empty flag of VC FIFO i.
- `continuar`  in  4  per-VC enable from flow control; 0 = VC paused.
- `out_almost_full`  in  1  almost-full flag of FIFO 4.
- `out_full`  in  1  full flag of FIFO 4.
- `pop`  out  4  one-hot read strobe to VC FIFO i (combinational).
- `sel`  out  2  registered VC index currently granted.
- `push`  out  1  write strobe to FIFO 4 (registered).
- `push_sel`  out  2  mux select aligned with `push`.
- `busy`  out  1  high while a grant is held.

## Operation
- Definitions:
  - `eligible[i] = !empty[i] && continuar[i]`.
  - `blocked = out_almost_full || out_full`.
- `last` register (2 bits) records the most recently granted VC.
- FSM with two states, IDLE and BURST.
- IDLE:
  - `pop = 0`.
  - If any VC is eligible and `!blocked`: winner is the first eligible VC in order `last+1, last+2, last+3, last` (mod 4).
  - On that edge: `sel <= winner`, `last <= winner`, `cnt <= 0`, go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - `pop[sel] = eligible[sel] && !blocked`; all other pop bits are 0.
  - Each pop increments `cnt` (width `$clog2(BURST_LEN+1)`).
  - Pop with `cnt == BURST_LEN-1` goes to IDLE.
  - `eligible[sel] == 0` goes to IDLE without popping, whether the VC went empty or was paused.
  - `blocked` with `eligible[sel] == 1`: stay in BURST, no pop, grant held, `cnt` unchanged.
- `busy = (state == BURST)`.
- `push <= |pop`, `push_sel <= sel` every cycle. This matches the one-cycle read latency of the VC FIFOs.
- The almost-full threshold of FIFO 4 must leave at least 1 free entry, which absorbs the push still in flight when `blocked` rises.
- Simultaneous events:
  - `empty[sel]` rising in the same cycle a pop would occur: no pop, because `pop` is gated combinationally.
  - `continuar[sel]` dropping mid-burst: the burst ends that cycle and no pop is issued.
  - A VC that is non-eligible at arbitration is skipped; it is not starved more than 3 grants while eligible.
- Reset mid-operation: FSM returns to IDLE immediately. Any pending `push` is cleared (the data popped in that cycle is lost, which is acceptable because all FIFOs are reset together).

## Timing
- Reset values: `state=IDLE`, `last=3` (so VC0 wins first), `cnt=0`, `sel=0`, `push=0`, `push_sel=0`, `busy=0`, `pop=0`.
- Arbitration costs one cycle: the first `pop` comes one cycle after eligibility is seen in IDLE.
- `pop` to `push`: exactly 1 cycle.
- Back-to-back bursts have one idle (IDLE) cycle between them.
- Peak throughput is `BURST_LEN/(BURST_LEN+1)` pushes per cycle.
- `blocked` and `empty` act on `pop` in the same cycle (combinational); the FSM responds at the next edge.

## Structure
- Shared package `fc_pkg`:
  - `NUM_VC`.
  - FSM state enum (`ST_IDLE`, `ST_BURST`).
  - Default `BURST_LEN`.
- One sub-module, `rr_pick`: combinational rotate-priority encoder.
  - Inputs: `req[3:0]`, `last[1:0]`.
  - Outputs: `gnt_idx[1:0]`, `any`.
  - Unit-testable on its own.

## Test plan
- Reset release with all `empty=4'b1111` → `pop=0`, `push=0`, `busy=0` indefinitely.
- `empty=4'b0000`, `continuar=4'b1111`, `BURST_LEN=4`, output never blocked → grants VC0, VC1, VC2, VC3, VC0 in that order. Each grant gives 4 pops then 1 idle cycle; each `push` lags its `pop` by one cycle with the matching `push_sel`.
- Only VC2 non-empty, `continuar=4'b0001` → no pops. Then set `continuar=4'b0100` → VC2 is granted.
- Mid-burst on VC1, raise `out_almost_full` for 3 cycles → `pop=0` for 3 cycles, `sel=1` held, `cnt` unchanged; the burst resumes afterwards and still totals 4 pops.
- VC3 granted with 2 entries → 2 pops; `empty[3]` rises, `pop[3]` is never asserted while empty, FSM returns to IDLE and the next grant goes to VC0.
- Assert `reset` asynchronously while `pop` is active → all outputs are 0 immediately; after release, the first grant is VC0.

Source files
------------

// File: rtl/vc_rr_arbiter_pkg.sv
// fc_pkg: shared constants and FSM state type for the VC round-robin arbiter
package fc_pkg;
  localparam int NUM_VC = 4;
  localparam int DEF_BURST_LEN = 4;
  typedef enum logic {ST_IDLE, ST_BURST} state_t;
endpackage

// File: rtl/vc_rr_arbiter_if.sv
// vc_rr_arbiter_if: FIFO status in, pop/push strobes and mux selects out.
// master = arbiter side, slave = FIFO/datapath side.
interface vc_rr_arbiter_if;
  import fc_pkg::*;
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] continuar;
  logic out_almost_full;
  logic out_full;
  logic [NUM_VC-1:0] pop;
  logic [1:0] sel;
  logic push;
  logic [1:0] push_sel;
  logic busy;
  modport master (
    input  empty, continuar, out_almost_full, out_full,
    output pop, sel, push, push_sel, busy
  );
  modport slave (
    output empty, continuar, out_almost_full, out_full,
    input  pop, sel, push, push_sel, busy
  );
endinterface

// File: rtl/vc_rr_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder; first set req in order last+1, last+2, last+3, last.
// Ports: req (requests), last (previous winner), gnt_idx (winner), any (some request set).
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       any
);
  // Scan from farthest to nearest so the nearest requester after last overwrites.
  always_comb begin
    gnt_idx = last;
    for (int k = 4; k >= 1; k--)
      if (req[last + 2'(k)]) gnt_idx = last + 2'(k);
  end
  assign any = |req;
endmodule

// File: rtl/vc_rr_arbiter.sv
// vc_rr_arbiter: round-robin burst scheduler draining four VC FIFOs into one output FIFO.
// Ports: clk, reset (async, active-high); bus (master): empty/continuar/out_almost_full/out_full in,
// pop (combinational), sel, push, push_sel (registered), busy out.
module vc_rr_arbiter
  import fc_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input logic clk,
  input logic reset,
  vc_rr_arbiter_if.master bus
);
  localparam int CW = $clog2(BURST_LEN + 1);
  state_t state_q, state_d;
  logic [1:0] sel_q, sel_d, last_q, last_d, push_sel_q, gnt_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] eligible, pop;
  logic blocked, any, push_q;
  assign eligible = ~bus.empty & bus.continuar;
  assign blocked = bus.out_almost_full | bus.out_full;
  rr_pick u_pick (.req(eligible), .last(last_q), .gnt_idx(gnt_idx), .any(any));
  // pop is gated combinationally so an empty/paused/blocked VC is never read.
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    cnt_d = cnt_q;
    pop = '0;
    if (state_q == ST_IDLE) begin
      if (any && !blocked) begin
        state_d = ST_BURST;
        sel_d = gnt_idx;
        last_d = gnt_idx;
        cnt_d = '0;
      end
    end else if (!eligible[sel_q]) begin
      state_d = ST_IDLE;
    end else if (!blocked) begin
      pop[sel_q] = 1'b1;
      cnt_d = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(BURST_LEN - 1)) ? ST_IDLE : ST_BURST;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q <= '0;
      last_q <= 2'd3;
      cnt_q <= '0;
      push_q <= 1'b0;
      push_sel_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      push_q <= |pop;
      push_sel_q <= sel_q;
    end
  end
  assign bus.pop = pop;
  assign bus.sel = sel_q;
  assign bus.push = push_q;
  assign bus.push_sel = push_sel_q;
  assign bus.busy = (state_q == ST_BURST);
endmodule

// File: tb/tb_vc_rr_arbiter.sv
// tb_vc_rr_arbiter: directed self-checking bench for vc_rr_arbiter with BURST_LEN=4
module tb_vc_rr_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int pass_cnt = 0;
  int total = 0;
  vc_rr_arbiter_if bus ();
  vc_rr_arbiter #(.BURST_LEN(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // observed = {pop, sel, busy, push, push_sel}
  logic [9:0] obs;
  assign obs = {bus.pop, bus.sel, bus.busy, bus.push, bus.push_sel};
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.empty = 4'hF;
    bus.continuar = 4'hF;
    bus.out_almost_full = 1'b0;
    bus.out_full = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      #1;
      total++;
      if (obs !== 10'b0) $display("FAIL reset_idle c%0d: got %b want %b", c, obs, 10'b0);
      else pass_cnt++;
      cyc();
    end
  endtask
  task automatic test_round_robin();
    logic [3:0] ep, ppop;
    logic [1:0] es, psel;
    logic eb;
    int p, g;
    do_reset();
    bus.empty = 4'h0;
    ppop = '0;
    psel = '0;
    for (int c = 0; c < 26; c++) begin
      ep = '0; es = '0; eb = 1'b0;
      if (c > 0) begin
        p = (c - 1) % 5;
        g = ((c - 1) / 5) % 4;
        es = 2'(g);
        eb = (p < 4);
        ep = (p < 4) ? (4'b0001 << g) : 4'b0000;
      end
      #1;
      total++;
      if (obs !== {ep, es, eb, |ppop, psel})
        $display("FAIL round_robin c%0d: got %b want %b", c, obs, {ep, es, eb, |ppop, psel});
      else pass_cnt++;
      ppop = ep;
      psel = es;
      cyc();
    end
  endtask
  task automatic test_paused();
    do_reset();
    bus.empty = 4'b1011;
    bus.continuar = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (obs !== 10'b0) $display("FAIL paused_no_pop c%0d: got %b want %b", c, obs, 10'b0);
      else pass_cnt++;
      cyc();
    end
    bus.continuar = 4'b0100;
    #1;
    total++;
    if (obs !== 10'b0) $display("FAIL unpause_arb: got %b want %b", obs, 10'b0);
    else pass_cnt++;
    cyc();
    #1;
    total++;
    if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0, 2'd0})
      $display("FAIL unpause_grant_vc2: got %b want %b", obs, {4'b0100, 2'd2, 1'b1, 1'b0, 2'd0});
    else pass_cnt++;
  endtask
  task automatic test_backpressure();
    logic [3:0] ep, ppop;
    logic [1:0] es, psel;
    logic eb;
    do_reset();
    bus.empty = 4'h0;
    bus.continuar = 4'b0010;
    ppop = '0;
    psel = '0;
    for (int c = 0; c < 9; c++) begin
      bus.out_almost_full = (c == 3 || c == 4);
      bus.out_full = (c == 5);
      ep = (c == 1 || c == 2 || c == 6 || c == 7) ? 4'b0010 : 4'b0000;
      es = (c == 0) ? 2'd0 : 2'd1;
      eb = (c >= 1 && c <= 7);
      #1;
      total++;
      if (obs !== {ep, es, eb, |ppop, psel})
        $display("FAIL backpressure c%0d: got %b want %b", c, obs, {ep, es, eb, |ppop, psel});
      else pass_cnt++;
      ppop = ep;
      psel = es;
      cyc();
    end
    bus.out_almost_full = 1'b0;
    bus.out_full = 1'b0;
  endtask
  task automatic test_drain();
    logic [3:0] ep, ppop;
    logic [1:0] es, psel;
    logic eb;
    do_reset();
    ppop = '0;
    psel = '0;
    for (int c = 0; c < 6; c++) begin
      bus.empty = (c < 3) ? 4'b0111 : (c == 3) ? 4'b1111 : 4'b0000;
      ep = (c == 1 || c == 2) ? 4'b1000 : (c == 5) ? 4'b0001 : 4'b0000;
      es = (c >= 1 && c <= 4) ? 2'd3 : 2'd0;
      eb = (c >= 1 && c <= 3) || c == 5;
      #1;
      total++;
      if (obs !== {ep, es, eb, |ppop, psel})
        $display("FAIL drain c%0d: got %b want %b", c, obs, {ep, es, eb, |ppop, psel});
      else pass_cnt++;
      ppop = ep;
      psel = es;
      cyc();
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    bus.empty = 4'h0;
    cyc();
    cyc();
    #1;
    total++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b1, 2'd0})
      $display("FAIL pre_reset_pop: got %b want %b", obs, {4'b0001, 2'd0, 1'b1, 1'b1, 2'd0});
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs !== 10'b0) $display("FAIL async_reset_clear: got %b want %b", obs, 10'b0);
    else pass_cnt++;
    cyc();
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 10'b0) $display("FAIL post_reset_idle: got %b want %b", obs, 10'b0);
    else pass_cnt++;
    cyc();
    #1;
    total++;
    if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0, 2'd0})
      $display("FAIL post_reset_vc0: got %b want %b", obs, {4'b0001, 2'd0, 1'b1, 1'b0, 2'd0});
    else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_paused();
    test_backpressure();
    test_drain();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
